// File: rtl/mul8_pkg.sv
// mul8_pkg: shared definitions for the time-shared 8x8 multiplier.
//   state_t  - controller state encoding (IDLE, MUL, RESP)
//   OP_W     - operand width
//   HALF_W   - nibble width fed to the 4x4 multiplier
//   PROD_W   - product / accumulator width
//   STEP_CNT - partial-product steps per operation
package mul8_pkg;

    localparam int OP_W     = 8;
    localparam int HALF_W   = 4;
    localparam int PROD_W   = 16;
    localparam int STEP_CNT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/multiCS4_v1.sv
// multiCS4_v1: combinational 4x4 unsigned carry-save multiplier.
//   a_i [3:0] - multiplicand nibble
//   b_i [3:0] - multiplier nibble
//   p_o [7:0] - product
// Four partial-product rows are reduced by two carry-save stages,
// then merged by a single carry-propagate add.
module multiCS4_v1
    import mul8_pkg::*;
(
    input  logic [HALF_W-1:0]   a_i,
    input  logic [HALF_W-1:0]   b_i,
    output logic [2*HALF_W-1:0] p_o
);

    logic [2*HALF_W-1:0] r0, r1, r2, r3;
    logic [2*HALF_W-1:0] s1, c1, s2, c2;

    always_comb begin
        r0 = {4'b0, a_i & {HALF_W{b_i[0]}}};
        r1 = {3'b0, a_i & {HALF_W{b_i[1]}}, 1'b0};
        r2 = {2'b0, a_i & {HALF_W{b_i[2]}}, 2'b0};
        r3 = {1'b0, a_i & {HALF_W{b_i[3]}}, 3'b0};
        // s + c always equals the true partial sum (<= 225), so no carry
        // can ever be shifted out of the top bit.
        s1 = r0 ^ r1 ^ r2;
        c1 = ((r0 & r1) | (r0 & r2) | (r1 & r2)) << 1;
        s2 = s1 ^ c1 ^ r3;
        c2 = ((s1 & c1) | (s1 & r3) | (c1 & r3)) << 1;
        p_o = s2 + c2;
    end

endmodule

// File: rtl/mul8_shared_seq.sv
// mul8_shared_seq: two-requester 8x8 unsigned multiplier sharing one 4x4
// multiplier over four steps.
//   RR_EN        - 1: round-robin arbitration, 0: requester 0 always wins
//   clk_i        - clock
//   rst_ni       - asynchronous active-low reset
//   req_valid_i  - per-requester operand valid
//   req_a_i      - packed multiplicands, requester k at [8k+7:8k]
//   req_b_i      - packed multipliers, same packing
//   req_ready_o  - per-requester accept (one-hot, IDLE only)
//   rsp_valid_o  - result available
//   rsp_id_o     - requester owning the result
//   rsp_prod_o   - 16-bit product
//   rsp_ready_i  - consumer accepts the result
//   busy_o       - controller not idle
//
// state | meaning
// IDLE  | waiting for a request; arbitration active
// MUL   | one partial product accumulated per cycle, steps 0..3
// RESP  | product presented until the consumer takes it
module mul8_shared_seq
    import mul8_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [1:0]        req_valid_i,
    input  logic [2*OP_W-1:0] req_a_i,
    input  logic [2*OP_W-1:0] req_b_i,
    output logic [1:0]        req_ready_o,
    output logic              rsp_valid_o,
    output logic              rsp_id_o,
    output logic [PROD_W-1:0] rsp_prod_o,
    input  logic              rsp_ready_i,
    output logic              busy_o
);

    state_t state, state_nxt;

    logic [1:0]          grant;
    logic                rr_last;
    logic [OP_W-1:0]     a_q, b_q;
    logic                id_q;
    logic [1:0]          step_q;
    logic                last_step;
    logic [PROD_W-1:0]   acc_q, prod_q;
    logic [HALF_W-1:0]   a_nib, b_nib;
    logic [2*HALF_W-1:0] pp;
    logic [PROD_W-1:0]   pp_sh, acc_sum;

    assign last_step = (step_q == 2'(STEP_CNT - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    // rr_last holds the id granted last; its reset value of 1 makes
    // requester 0 win the first contention.
    always_comb begin
        state_nxt = state;
        grant     = 2'b00;
        case (state)
            IDLE: begin
                if (req_valid_i[0] && (!req_valid_i[1] || RR_EN == 0 || rr_last))
                    grant = 2'b01;
                else if (req_valid_i[1])
                    grant = 2'b10;
                if (grant != 2'b00) state_nxt = MUL;
            end
            MUL:     if (last_step)   state_nxt = RESP;
            RESP:    if (rsp_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Keep ready low while reset is held even though the state reads IDLE.
    assign req_ready_o = grant & {2{rst_ni}};
    assign rsp_valid_o = (state == RESP);
    assign busy_o      = (state != IDLE);
    assign rsp_id_o    = id_q;
    assign rsp_prod_o  = prod_q;

    // Step k selects the A nibble by bit 0 and the B nibble by bit 1.
    assign a_nib = step_q[0] ? a_q[OP_W-1:HALF_W] : a_q[HALF_W-1:0];
    assign b_nib = step_q[1] ? b_q[OP_W-1:HALF_W] : b_q[HALF_W-1:0];

    multiCS4_v1 u_mul4 (
        .a_i (a_nib),
        .b_i (b_nib),
        .p_o (pp)
    );

    always_comb begin
        pp_sh = PROD_W'(pp);
        case (step_q)
            2'd0:       pp_sh = PROD_W'(pp);
            2'd1, 2'd2: pp_sh = PROD_W'(pp) << HALF_W;
            default:    pp_sh = PROD_W'(pp) << OP_W;
        endcase
        acc_sum = acc_q + pp_sh;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
            step_q  <= 2'd0;
            acc_q   <= '0;
            prod_q  <= '0;
            rr_last <= 1'b1;
        end else if (state == IDLE && grant != 2'b00) begin
            a_q     <= grant[1] ? req_a_i[2*OP_W-1:OP_W] : req_a_i[OP_W-1:0];
            b_q     <= grant[1] ? req_b_i[2*OP_W-1:OP_W] : req_b_i[OP_W-1:0];
            id_q    <= grant[1];
            step_q  <= 2'd0;
            acc_q   <= '0;
            rr_last <= grant[1];
        end else if (state == MUL) begin
            acc_q  <= acc_sum;
            step_q <= step_q + 2'd1;
            if (last_step) prod_q <= acc_sum;
        end
    end

endmodule

// File: tb/tb_mul8_shared_seq.sv
// tb_mul8_shared_seq: directed and random checks of mul8_shared_seq,
// round-robin instance (dut) plus a fixed-priority instance (dut_fp).
module tb_mul8_shared_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [1:0]  req_valid, req_ready;
    logic [15:0] req_a, req_b, rsp_prod;
    logic        rsp_valid, rsp_id, rsp_ready, busy;

    logic [1:0]  fp_valid, fp_ready;
    logic [15:0] fp_a, fp_b, fp_prod;
    logic        fp_rsp_valid, fp_rsp_id, fp_rsp_ready, fp_busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    mul8_shared_seq #(.RR_EN(1)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_ready_o (req_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_id_o    (rsp_id),
        .rsp_prod_o  (rsp_prod),
        .rsp_ready_i (rsp_ready),
        .busy_o      (busy)
    );

    mul8_shared_seq #(.RR_EN(0)) dut_fp (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (fp_valid),
        .req_a_i     (fp_a),
        .req_b_i     (fp_b),
        .req_ready_o (fp_ready),
        .rsp_valid_o (fp_rsp_valid),
        .rsp_id_o    (fp_rsp_id),
        .rsp_prod_o  (fp_prod),
        .rsp_ready_i (fp_rsp_ready),
        .busy_o      (fp_busy)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present operands on requester k and return just after the accept edge.
    task automatic send(input int k, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        req_valid[k]     = 1'b1;
        req_a[8*k +: 8]  = a;
        req_b[8*k +: 8]  = b;
        #1;
        while (!req_ready[k] && n < 50) begin
            tick();
            n++;
        end
        chk("send_rdy", 16'(req_ready[k]), 16'h1);
        tick();
        req_valid[k] = 1'b0;
    endtask

    // Count edges after the accept edge until rsp_valid rises.
    task automatic wait_rsp(output int lat, output logic [15:0] prod, output logic id);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("rsp_valid", 16'(rsp_valid), 16'h1);
        prod = rsp_prod;
        id   = rsp_id;
    endtask

    task automatic run_op(input string tag, input int k, input logic [7:0] a,
                          input logic [7:0] b, input logic [15:0] exp);
        int          lat;
        logic [15:0] prod;
        logic        id;
        send(k, a, b);
        wait_rsp(lat, prod, id);
        chk({tag, "_lat"}, 16'(lat), 16'd4);
        chk({tag, "_prod"}, prod, exp);
        chk({tag, "_id"}, 16'(id), 16'(k));
        tick();
        chk({tag, "_idle"}, 16'(busy), 16'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, n, fp_seen, n_acc, n_rsp, cyc;
        logic [15:0] prod;
        logic        id;
        logic [1:0]  took;
        logic [16:0] exp_q[$];
        logic [16:0] e;

        req_valid = 2'b11; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        fp_valid = 2'b00; fp_a = '0; fp_b = '0; fp_rsp_ready = 1'b1;

        // reset values, with both requesters valid
        repeat (3) tick();
        chk("rst_ready", 16'(req_ready), 16'h0);
        chk("rst_valid", 16'(rsp_valid), 16'h0);
        chk("rst_prod", rsp_prod, 16'h0000);
        chk("rst_id", 16'(rsp_id), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        req_valid = 2'b00;
        rst_ni = 1'b1;
        tick();

        // contention, round-robin; in-flight operand changes ignored
        req_a = {8'hAB, 8'h12};
        req_b = {8'hCD, 8'h34};
        req_valid = 2'b11;
        #1;
        chk("rr_first", 16'(req_ready), 16'h1);
        tick();
        req_valid[0] = 1'b0;
        req_a[7:0] = 8'hEE;
        req_b[7:0] = 8'hEE;
        #1;
        chk("mul_rdy", 16'(req_ready), 16'h0);
        wait_rsp(lat, prod, id);
        chk("rr0_lat", 16'(lat), 16'd4);
        chk("rr0_prod", prod, 16'h03A8);
        chk("rr0_id", 16'(id), 16'h0);
        tick();
        chk("rr_second", 16'(req_ready), 16'h2);
        tick();
        req_valid[1] = 1'b0;
        req_a[15:8] = 8'h11;
        wait_rsp(lat, prod, id);
        chk("rr1_lat", 16'(lat), 16'd4);
        chk("rr1_prod", prod, 16'h88EF);
        chk("rr1_id", 16'(id), 16'h1);
        tick();

        run_op("ff", 0, 8'hFF, 8'hFF, 16'hFE01);
        run_op("zero", 1, 8'h00, 8'h7F, 16'h0000);
        run_op("pow2", 1, 8'h80, 8'h02, 16'h0100);

        // consumer back-pressure
        rsp_ready = 1'b0;
        send(0, 8'h25, 8'h03);
        wait_rsp(lat, prod, id);
        chk("bp_lat", 16'(lat), 16'd4);
        chk("bp_prod", prod, 16'h006F);
        req_valid = 2'b11;
        repeat (10) begin
            tick();
            chk("hold_valid", 16'(rsp_valid), 16'h1);
            chk("hold_prod", rsp_prod, 16'h006F);
            chk("hold_rdy", 16'(req_ready), 16'h0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_idle", 16'(busy), 16'h0);
        chk("bp_valid_low", 16'(rsp_valid), 16'h0);
        chk("bp_rr", 16'(req_ready), 16'h2);
        req_valid = 2'b00;
        tick();

        // reset during MUL step 2
        send(1, 8'h55, 8'h66);
        tick();
        tick();
        req_valid = 2'b01;
        rst_ni = 1'b0;
        #1;
        chk("mr_valid", 16'(rsp_valid), 16'h0);
        chk("mr_busy", 16'(busy), 16'h0);
        chk("mr_prod", rsp_prod, 16'h0000);
        chk("mr_id", 16'(rsp_id), 16'h0);
        chk("mr_ready", 16'(req_ready), 16'h0);
        tick();
        tick();
        req_valid = 2'b00;
        rst_ni = 1'b1;
        repeat (8) begin
            tick();
            chk("mr_no_rsp", 16'(rsp_valid), 16'h0);
        end
        req_a = {8'h77, 8'h0F};
        req_b = {8'h77, 8'h10};
        req_valid = 2'b11;
        #1;
        chk("mr_pri", 16'(req_ready), 16'h1);
        tick();
        req_valid = 2'b00;
        wait_rsp(lat, prod, id);
        chk("mr_lat", 16'(lat), 16'd4);
        chk("mr_prod2", prod, 16'h00F0);
        chk("mr_id2", 16'(id), 16'h0);
        tick();

        // fixed priority: requester 1 starved while requester 0 stays valid
        fp_a = {8'h03, 8'h05};
        fp_b = {8'h07, 8'h09};
        fp_valid = 2'b11;
        fp_seen = 0;
        repeat (40) begin
            tick();
            chk("fp_no_g1", 16'(fp_ready[1]), 16'h0);
            if (fp_rsp_valid) begin
                chk("fp_id", 16'(fp_rsp_id), 16'h0);
                chk("fp_prod", fp_prod, 16'd45);
                fp_seen++;
            end
        end
        chk("fp_count", 16'(fp_seen >= 5), 16'h1);
        fp_valid = 2'b10;
        #1;
        n = 0;
        while (!fp_ready[1] && n < 20) begin
            tick();
            n++;
        end
        chk("fp_single", 16'(fp_ready[1]), 16'h1);
        tick();
        fp_valid = 2'b00;
        n = 0;
        while (!fp_rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk("fp_single_id", 16'(fp_rsp_id), 16'h1);
        chk("fp_single_prod", fp_prod, 16'h0015);
        repeat (3) tick();
        chk("fp_idle", 16'(fp_busy), 16'h0);

        // random traffic with a scoreboard in accept order
        n_acc = 0;
        n_rsp = 0;
        cyc = 0;
        req_valid = 2'b00;
        while (!(n_acc >= 1000 && n_rsp == n_acc) && cyc < 30000) begin
            for (int k = 0; k < 2; k++) begin
                if (!req_valid[k] && n_acc < 1000 && $urandom_range(0, 1) == 1) begin
                    req_valid[k]    = 1'b1;
                    req_a[8*k +: 8] = 8'($urandom);
                    req_b[8*k +: 8] = 8'($urandom);
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            chk("rdy_mask", 16'(req_ready & ~req_valid), 16'h0);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("dup_rsp", 16'(exp_q.size()), 16'h1);
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_prod", rsp_prod, e[15:0]);
                    chk("rnd_id", 16'(rsp_id), 16'(e[16]));
                end
                n_rsp++;
            end
            took = 2'b00;
            for (int k = 0; k < 2; k++) begin
                if (req_valid[k] && req_ready[k]) begin
                    exp_q.push_back({k[0], 16'(req_a[8*k +: 8]) * 16'(req_b[8*k +: 8])});
                    n_acc++;
                    took[k] = 1'b1;
                end
            end
            tick();
            cyc++;
            req_valid = req_valid & ~took;
        end
        chk("rnd_lost", 16'(exp_q.size()), 16'h0);
        chk("rnd_balance", 16'(n_acc == n_rsp), 16'h1);
        chk("rnd_volume", 16'(n_acc >= 1000), 16'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
